mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back select for the MIPS-32 core; sits directly downstream of MEM_stage.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mem_wb_stage_load_align.sv | 38 +++
 rtl/mem_wb_stage.sv | 86 ++++++++
 tb/tb_mem_wb_stage.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-32 core definitions: opcode constants, default widths and the load-opcode decode helper.
package mips_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;

  // Any opcode whose write-back value comes from memory rather than the ALU.
  function automatic logic is_load_op(input logic [5:0] op);
    is_load_op = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
                 (op == OP_LH) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Little-endian sub-word extraction for lb/lbu/lh/lhu; used only when MEM_WB_LOAD_EXT_EN is defined.
module load_align
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [5:0]        in_opcode,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] in_load_data,
  output logic [DATA_W-1:0] out_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    ext_byte = {{(DATA_W-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    ext_half = {{(DATA_W-16){sgn & h[15]}}, h};
  endfunction

  assign w_byte = in_load_data[{addr, 3'b000} +: 8];
  assign w_half = in_load_data[{addr[1], 4'b0000} +: 16];

  always_comb begin
    out_data = in_load_data;
    case (in_opcode)
      OP_LB:   out_data = ext_byte(w_byte, 1'b1);
      OP_LBU:  out_data = ext_byte(w_byte, 1'b0);
      OP_LH:   out_data = ext_half(w_half, 1'b1);
      OP_LHU:  out_data = ext_half(w_half, 1'b0);
      default: out_data = in_load_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-back data select and retired-instruction counter.
// Define MEM_WB_LOAD_EXT_EN to enable sub-word (lb/lbu/lh/lhu) extraction via load_align.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [5:0]            in_opcode,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_load_data,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [CNT_W-1:0]      retired_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]     w_load_word;
  logic [DATA_W-1:0]     w_sel_data;
  logic                  w_we;

  logic                  r_vld_p1;
  logic                  r_we_p1;
  logic [REG_ADDR_W-1:0] r_addr_p1;
  logic [DATA_W-1:0]     r_data_p1;
  logic [CNT_W-1:0]      r_cnt;

`ifdef MEM_WB_LOAD_EXT_EN
  load_align #(.DATA_W(DATA_W)) u_load_align (
    .in_opcode    (in_opcode),
    .addr         (in_alu_result[1:0]),
    .in_load_data (in_load_data),
    .out_data     (w_load_word)
  );
`else
  assign w_load_word = in_load_data;
`endif

  always_comb begin
    w_sel_data = in_alu_result;
    if (is_load_op(in_opcode)) w_sel_data = w_load_word;
  end

  // $0 is hard-wired zero, so a write to it never reaches the register file.
  assign w_we = in_valid & in_reg_write & (in_dest != '0);

  // ---- MEM -> WB boundary (p0 -> p1) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_we_p1   <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
      r_cnt     <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      r_vld_p1  <= 1'b0;
      r_we_p1   <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
    end else if (!stall) begin
      r_vld_p1  <= 1'b1;
      r_we_p1   <= w_we;
      r_addr_p1 <= in_dest;
      r_data_p1 <= w_sel_data;
      r_cnt     <= r_cnt + CNT_ONE;
    end
  end

  assign wb_valid    = r_vld_p1;
  assign wb_we       = r_we_p1;
  assign wb_addr     = r_addr_p1;
  assign wb_data     = r_data_p1;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; expectations follow MEM_WB_LOAD_EXT_EN when it is defined.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid, in_reg_write;
  logic [5:0]  in_opcode;
  logic [4:0]  in_dest;
  logic [31:0] in_alu_result, in_load_data;

  logic        wb_valid, wb_we, n_valid, n_we;
  logic [4:0]  wb_addr, n_addr;
  logic [31:0] wb_data, n_data;
  logic [31:0] retired_cnt;
  logic [3:0]  n_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_reg_write(in_reg_write), .in_dest(in_dest),
    .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .retired_cnt(retired_cnt)
  );

  mem_wb_stage #(.CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_reg_write(in_reg_write), .in_dest(in_dest),
    .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .wb_valid(n_valid), .wb_we(n_we), .wb_addr(n_addr), .wb_data(n_data),
    .retired_cnt(n_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] c);
    chk({tag, ".valid"}, {31'b0, wb_valid}, {31'b0, v});
    chk({tag, ".we"},    {31'b0, wb_we},    {31'b0, we});
    chk({tag, ".addr"},  {27'b0, wb_addr},  {27'b0, a});
    chk({tag, ".data"},  wb_data,           d);
    chk({tag, ".cnt"},   retired_cnt,       c);
    chk({tag, ".cnt4"},  {28'b0, n_cnt},    {28'b0, c[3:0]});
  endtask

  // Drive one MEM-stage instruction, then sample just after the capturing edge.
  task automatic drive(input logic v, input logic [5:0] op, input logic rw, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] ld, input logic st, input logic fl);
    in_valid = v; in_opcode = op; in_reg_write = rw; in_dest = d;
    in_alu_result = alu; in_load_data = ld; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_lb, exp_lhu, exp_lbu, exp_lh;

  initial begin
`ifdef MEM_WB_LOAD_EXT_EN
    exp_lb  = 32'hFFFF_FFF4;
    exp_lhu = 32'h0000_12F4;
    exp_lbu = 32'h0000_0056;
    exp_lh  = 32'hFFFF_8765;
`else
    exp_lb  = 32'h12F4_5678;
    exp_lhu = 32'h12F4_5678;
    exp_lbu = 32'h12F4_5678;
    exp_lh  = 32'h12F4_8765;
`endif
    rst = 1'b1; stall = 0; flush = 0; in_valid = 0; in_opcode = 0; in_reg_write = 0;
    in_dest = 0; in_alu_result = 0; in_load_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_wb("reset", 0, 0, 5'd0, 32'h0, 32'd0);
    rst = 1'b0;

    drive(1, 6'b100011, 1, 5'd8, 32'h100, 32'hDEAD_BEEF, 0, 0);
    chk_wb("lw", 1, 1, 5'd8, 32'hDEAD_BEEF, 32'd1);

    drive(1, 6'b000000, 1, 5'd0, 32'h5, 32'hFFFF_0000, 0, 0);
    chk_wb("rtype_r0", 1, 0, 5'd0, 32'h5, 32'd2);

    drive(1, 6'b001000, 1, 5'd3, 32'h7, 32'hCAFE_0000, 0, 0);
    chk_wb("addi", 1, 1, 5'd3, 32'h7, 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'b100011, 1, 5'd9, 32'hAA, 32'h5555_5555, 1, 0);
      chk_wb("stall", 1, 1, 5'd3, 32'h7, 32'd3);
    end
    drive(1, 6'b100011, 1, 5'd9, 32'hAA, 32'h5555_5555, 1, 1);
    chk_wb("flush_stall", 0, 0, 5'd0, 32'h0, 32'd3);

    drive(1, 6'b001000, 1, 5'd4, 32'h11, 32'h0, 0, 0);
    chk_wb("addi2", 1, 1, 5'd4, 32'h11, 32'd4);
    drive(0, 6'b100011, 1, 5'd6, 32'h99, 32'h1234, 0, 0);
    chk_wb("invalid", 0, 0, 5'd0, 32'h0, 32'd4);
    drive(1, 6'b001000, 1, 5'd7, 32'h22, 32'h0, 0, 1);
    chk_wb("flush", 0, 0, 5'd0, 32'h0, 32'd4);

    drive(1, 6'b101011, 0, 5'd5, 32'h44, 32'h7777_7777, 0, 0);
    chk_wb("sw", 1, 0, 5'd5, 32'h44, 32'd5);

    drive(1, 6'b100000, 1, 5'd10, 32'h102, 32'h12F4_5678, 0, 0);
    chk_wb("lb", 1, 1, 5'd10, exp_lb, 32'd6);
    drive(1, 6'b100101, 1, 5'd11, 32'h102, 32'h12F4_5678, 0, 0);
    chk_wb("lhu", 1, 1, 5'd11, exp_lhu, 32'd7);
    drive(1, 6'b100100, 1, 5'd12, 32'h101, 32'h12F4_5678, 0, 0);
    chk_wb("lbu", 1, 1, 5'd12, exp_lbu, 32'd8);
    drive(1, 6'b100001, 1, 5'd13, 32'h100, 32'h12F4_8765, 0, 0);
    chk_wb("lh", 1, 1, 5'd13, exp_lh, 32'd9);

    // Asynchronous reset: outputs clear with no clock edge in between.
    in_valid = 0; flush = 0; stall = 0;
    #1 rst = 1'b1;
    #1;
    chk_wb("async_rst", 0, 0, 5'd0, 32'h0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 17; i++)
      drive(1, 6'b000000, 1, 5'd1, 32'(i), 32'h0, 0, 0);
    chk_wb("wrap", 1, 1, 5'd1, 32'd16, 32'd17);
    chk("wrap.cnt4_is_1", {28'b0, n_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
